// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: time-multiplexed 7-segment driver for a packed BCD word.
// Shadow-latched digits, leading-zero blanking, per-digit dp, anti-ghost gap.
module bcd_seg_scanner #(
  parameter  int DIGITS = 8,
  parameter  int DIV    = 1000,
  parameter  int GAP    = 1,
  localparam int SW     = $clog2(DIGITS),
  localparam int CW     = $clog2(DIV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_en,
  output logic [7:0]            seg_n,
  output logic [DIGITS-1:0]     an_n,
  output logic [SW-1:0]         slot
);

  logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [CW-1:0]       div_cnt_q, div_cnt_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [7:0]          seg_n_q, seg_n_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;

  logic                gap_phase;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          nib;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = 7'h3F;
      4'd1:    g = 7'h06;
      4'd2:    g = 7'h5B;
      4'd3:    g = 7'h4F;
      4'd4:    g = 7'h66;
      4'd5:    g = 7'h6D;
      4'd6:    g = 7'h7D;
      4'd7:    g = 7'h07;
      4'd8:    g = 7'h7F;
      4'd9:    g = 7'h6F;
      default: g = 7'h79;
    endcase
    return g;
  endfunction

  generate
    if (GAP == 0) begin : g_nogap
      assign gap_phase = 1'b0;
    end else begin : g_gap
      assign gap_phase = div_cnt_q < CW'(GAP);
    end
  endgenerate

  always_comb begin
    shadow_bcd_d = load ? bcd_in : shadow_bcd_q;
    shadow_dp_d  = load ? dp_in  : shadow_dp_q;
  end

  always_comb begin
    div_cnt_d = div_cnt_q + CW'(1);
    slot_d    = slot_q;
    if (div_cnt_q == CW'(DIV - 1)) begin
      div_cnt_d = '0;
      slot_d    = (slot_q == SW'(DIGITS - 1)) ? '0 : slot_q + SW'(1);
    end
  end

  // Scan from the MSD down; a digit blanks only while everything above it is zero.
  always_comb begin
    logic za;
    za    = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      za       = za & (shadow_bcd_q[4*i +: 4] == 4'd0);
      blank[i] = (i != 0) && lz_en && za;
    end
  end

  assign nib = shadow_bcd_q[{slot_q, 2'b00} +: 4];

  always_comb begin
    seg_n_d = 8'hFF;
    an_n_d  = '1;
    if (!gap_phase) begin
      an_n_d = ~(DIGITS'(1) << slot_q);
      if (!blank[slot_q]) begin
        seg_n_d = ~{shadow_dp_q[slot_q], glyph(nib)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      div_cnt_q    <= '0;
      slot_q       <= '0;
      seg_n_q      <= 8'hFF;
      an_n_q       <= '1;
    end else begin
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      div_cnt_q    <= div_cnt_d;
      slot_q       <= slot_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign an_n  = an_n_q;
  assign slot  = slot_q;

endmodule
